// File: rtl/ibf_insert_scheduler_pkg.sv
// Shared header for the IBF insert scheduler: key/set-length widths and FSM encoding.
package ibf_insert_scheduler_pkg;

    localparam int unsigned KEY_FIELD = 32;
    localparam int unsigned SET_LEN   = 16;
    localparam int unsigned STATE_W   = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/ibf_insert_scheduler_if.sv
// Requester, datapath and status bundle for the IBF insert scheduler.
interface ibf_insert_scheduler_if
    import ibf_insert_scheduler_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_FIELD,
    parameter int unsigned CNT_W = SET_LEN
);
    logic             req0_valid;
    logic [KEY_W-1:0] req0_key;
    logic             req0_last;
    logic             req0_ready;
    logic             req1_valid;
    logic [KEY_W-1:0] req1_key;
    logic             req1_last;
    logic             req1_ready;
    logic             dp_start;
    logic [KEY_W-1:0] dp_key;
    logic             dp_sel;
    logic             dp_done;
    logic [1:0]       ibf_done;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             busy;
    logic             err;

    modport master (
        output req0_valid, req0_key, req0_last, req1_valid, req1_key, req1_last, dp_done,
        input  req0_ready, req1_ready, dp_start, dp_key, dp_sel, ibf_done, cnt0, cnt1, busy, err
    );

    modport slave (
        input  req0_valid, req0_key, req0_last, req1_valid, req1_key, req1_last, dp_done,
        output req0_ready, req1_ready, dp_start, dp_key, dp_sel, ibf_done, cnt0, cnt1, busy, err
    );

endinterface

// File: rtl/ibf_insert_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt_c
);
    logic prio;

    always_comb begin
        gnt_c = 2'b00;
        if (req[0] && (!prio || !req[1])) begin
            gnt_c = 2'b01;
        end else if (req[1]) begin
            gnt_c = 2'b10;
        end
    end

    // prio = 1 means set 1 is preferred on the next tie
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (advance) begin
            prio <= gnt_c[0];
        end
    end

endmodule

// File: rtl/ibf_insert_scheduler.sv
// Feeds keys from two sets, one at a time, into the hash/IBF programming datapath.
module ibf_insert_scheduler
    import ibf_insert_scheduler_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_FIELD,
    parameter int unsigned CNT_W = SET_LEN,
    parameter int unsigned TMO   = 64
) (
    input  logic             clk,
    input  logic             reset,
    ibf_insert_scheduler_if.slave bus
);
    localparam int unsigned TMO_W = (TMO > 1) ? $clog2(TMO) : 1;

    logic [STATE_W-1:0] state, state_nxt;
    logic [1:0]         eligible, gnt;
    logic               accept, complete, err_set;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               last_q, dp_start_q, dp_sel_q, busy_q, err_q;
    logic [KEY_W-1:0]   dp_key_q;
    logic [1:0]         ibf_done_q;
    logic [CNT_W-1:0]   cnt0_q, cnt1_q;

    assign eligible = {bus.req1_valid & ~ibf_done_q[1], bus.req0_valid & ~ibf_done_q[0]};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (eligible),
        .advance (accept),
        .gnt_c   (gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        complete  = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                err_set = bus.dp_done;
                if (|gnt) begin
                    accept    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                err_set   = bus.dp_done;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.dp_done) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmo_cnt == TMO_W'(TMO - 1)) begin
                    err_set   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Key capture, completion bookkeeping and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_start_q <= 1'b0;
            dp_key_q   <= '0;
            dp_sel_q   <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            ibf_done_q <= 2'b00;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            tmo_cnt    <= '0;
        end else begin
            dp_start_q <= accept;
            busy_q     <= (state_nxt != ST_IDLE);
            if (accept) begin
                dp_key_q <= gnt[1] ? bus.req1_key  : bus.req0_key;
                dp_sel_q <= gnt[1];
                last_q   <= gnt[1] ? bus.req1_last : bus.req0_last;
            end
            if (state == ST_WAIT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (complete) begin
                if (!dp_sel_q && (cnt0_q != '1)) begin
                    cnt0_q <= cnt0_q + CNT_W'(1);
                end
                if (dp_sel_q && (cnt1_q != '1)) begin
                    cnt1_q <= cnt1_q + CNT_W'(1);
                end
                if (last_q) begin
                    ibf_done_q[dp_sel_q] <= 1'b1;
                end
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.req0_ready = accept & gnt[0];
    assign bus.req1_ready = accept & gnt[1];
    assign bus.dp_start   = dp_start_q;
    assign bus.dp_key     = dp_key_q;
    assign bus.dp_sel     = dp_sel_q;
    assign bus.ibf_done   = ibf_done_q;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_ibf_insert_scheduler.sv
// Bench for ibf_insert_scheduler: table of single-key steps plus arbitration, timeout, reset and saturation sequences.
module tb_ibf_insert_scheduler;
    localparam int unsigned KW  = 32;
    localparam int unsigned CW  = 16;
    localparam int unsigned SCW = 2;
    localparam int unsigned TMO = 64;

    typedef struct packed {
        logic [KW-1:0] key;
        logic          last;
    } kv_t;

    typedef struct packed {
        logic          sel;
        logic [KW-1:0] key;
    } exp_t;

    typedef struct {
        logic          sel;
        logic [KW-1:0] key;
        logic          last;
        logic          acc;
        int unsigned   c0;
        int unsigned   c1;
        logic [1:0]    done;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ibf_insert_scheduler_if #(.KEY_W(KW), .CNT_W(CW))  bus ();
    ibf_insert_scheduler_if #(.KEY_W(KW), .CNT_W(SCW)) sbus ();

    ibf_insert_scheduler #(.KEY_W(KW), .CNT_W(CW), .TMO(TMO)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    ibf_insert_scheduler #(.KEY_W(KW), .CNT_W(SCW), .TMO(TMO)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus.slave)
    );

    assign sbus.req0_valid = bus.req0_valid;
    assign sbus.req0_key   = bus.req0_key;
    assign sbus.req0_last  = bus.req0_last;
    assign sbus.req1_valid = bus.req1_valid;
    assign sbus.req1_key   = bus.req1_key;
    assign sbus.req1_last  = bus.req1_last;
    assign sbus.dp_done    = bus.dp_done;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          cd = 0;
    int          resp_delay = 2;
    bit          resp_en = 1'b1;
    bit          resp_early = 1'b0;
    bit          done_pulse = 1'b0;
    bit          seen_start = 1'b0;
    bit          busy_s = 1'b0;
    bit          hold_valid = 1'b0;
    logic [KW-1:0] held_key = '0;
    kv_t         q0[$];
    kv_t         q1[$];
    exp_t        exp_q[$];
    int          acc_q[$];
    vec_t        vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample/check at negedge, respond to datapath, advance drivers after posedge
    task automatic tick();
        logic t0, t1;
        exp_t e;
        kv_t  kv;
        @(negedge clk);
        cyc++;
        t0 = bus.req0_valid & bus.req0_ready;
        t1 = bus.req1_valid & bus.req1_ready;
        chk("ready_excl", 64'(bus.req0_ready & bus.req1_ready), 64'(0));
        chk("ready_busy", 64'((bus.req0_ready | bus.req1_ready) & bus.busy), 64'(0));
        if (t0 | t1) begin
            last_acc = cyc;
            acc_q.push_back(cyc);
        end
        if (bus.dp_start) begin
            seen_start = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_dp_start", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("dp_key", 64'(bus.dp_key), 64'(e.key));
                chk("dp_sel", 64'(bus.dp_sel), 64'(e.sel));
                chk("start_latency", 64'(cyc - last_acc), 64'(1));
                held_key   = e.key;
                hold_valid = 1'b1;
            end
        end else if (bus.busy && hold_valid) begin
            chk("dp_key_hold", 64'(bus.dp_key), 64'(held_key));
        end
        busy_s = bus.busy;
        bus.dp_done = done_pulse;
        done_pulse  = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) bus.dp_done = 1'b1;
        end
        if (bus.dp_start && resp_en) begin
            cd = resp_delay;
            if (resp_early) bus.dp_done = 1'b1;
        end
        @(posedge clk);
        #1;
        if (t0) bus.req0_valid = 1'b0;
        if (t1) bus.req1_valid = 1'b0;
        if (!bus.req0_valid && q0.size() > 0) begin
            kv = q0.pop_front();
            bus.req0_key = kv.key; bus.req0_last = kv.last; bus.req0_valid = 1'b1;
        end
        if (!bus.req1_valid && q1.size() > 0) begin
            kv = q1.pop_front();
            bus.req1_key = kv.key; bus.req1_last = kv.last; bus.req1_valid = 1'b1;
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        q0.delete(); q1.delete(); exp_q.delete();
        bus.req0_valid = 1'b0; bus.req0_key = '0; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_key = '0; bus.req1_last = 1'b0;
        bus.dp_done = 1'b0;
        cd = 0; done_pulse = 1'b0; resp_en = 1'b1; resp_early = 1'b0; hold_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        acc_q.delete();
    endtask

    task automatic send(input logic sel, input logic [KW-1:0] key, input logic last, input bit expect_go);
        kv_t  kv;
        exp_t e;
        kv.key = key; kv.last = last;
        if (sel) q1.push_back(kv); else q0.push_back(kv);
        if (expect_go) begin
            e.sel = sel; e.key = key;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input int bound);
        bit ok = 1'b0;
        seen_start = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            if (seen_start && !busy_s) ok = 1'b1;
        end
        if (!ok) chk("wait_idle_timeout", 64'(1), 64'(0));
    endtask

    task automatic check_quiet(input string tag, input logic err_exp);
        chk({tag, "_busy"},     64'(bus.busy),     64'(0));
        chk({tag, "_err"},      64'(bus.err),      64'(err_exp));
        chk({tag, "_dp_start"}, 64'(bus.dp_start), 64'(0));
        chk({tag, "_dp_key"},   64'(bus.dp_key),   64'(0));
        chk({tag, "_dp_sel"},   64'(bus.dp_sel),   64'(0));
        chk({tag, "_ibf_done"}, 64'(bus.ibf_done), 64'(0));
        chk({tag, "_cnt0"},     64'(bus.cnt0),     64'(0));
        chk({tag, "_cnt1"},     64'(bus.cnt1),     64'(0));
        chk({tag, "_ready"},    64'(bus.req0_ready | bus.req1_ready), 64'(0));
    endtask

    initial begin
        int n;
        vt[0] = '{sel: 1'b0, key: 32'hA5,        last: 1'b0, acc: 1'b1, c0: 1, c1: 0, done: 2'b00};
        vt[1] = '{sel: 1'b0, key: 32'h3C,        last: 1'b1, acc: 1'b1, c0: 2, c1: 0, done: 2'b01};
        vt[2] = '{sel: 1'b0, key: 32'h99,        last: 1'b0, acc: 1'b0, c0: 2, c1: 0, done: 2'b01};
        vt[3] = '{sel: 1'b1, key: 32'hDEADBEEF,  last: 1'b0, acc: 1'b1, c0: 2, c1: 1, done: 2'b01};
        vt[4] = '{sel: 1'b1, key: 32'h0000_0001, last: 1'b1, acc: 1'b1, c0: 2, c1: 2, done: 2'b11};
        vt[5] = '{sel: 1'b1, key: 32'h55,        last: 1'b0, acc: 1'b0, c0: 2, c1: 2, done: 2'b11};

        reset_dut();
        check_quiet("reset", 1'b0);

        // Single-key steps; ineligible sets must never be accepted
        for (int i = 0; i < 6; i++) begin
            send(vt[i].sel, vt[i].key, vt[i].last, vt[i].acc);
            if (vt[i].acc) begin
                wait_idle(100);
            end else begin
                for (int k = 0; k < 8; k++) tick();
                chk("blocked_busy",  64'(busy_s), 64'(0));
                chk("blocked_ready", 64'(bus.req0_ready | bus.req1_ready), 64'(0));
            end
            chk("vec_cnt0",     64'(bus.cnt0),     64'(vt[i].c0));
            chk("vec_cnt1",     64'(bus.cnt1),     64'(vt[i].c1));
            chk("vec_ibf_done", 64'(bus.ibf_done), 64'(vt[i].done));
        end
        chk("vec_err", 64'(bus.err), 64'(0));

        // Both sets continuously valid: grants alternate starting from set 0
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 32'h1000 + 32'(i), i == 3, 1'b0);
            send(1'b1, 32'h2000 + 32'(i), i == 3, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{sel: 1'b0, key: 32'h1000 + 32'(i)});
            exp_q.push_back('{sel: 1'b1, key: 32'h2000 + 32'(i)});
        end
        n = 0;
        while (n < 200 && !(bus.ibf_done == 2'b11 && !bus.busy)) begin
            tick();
            n++;
        end
        chk("rr_cnt0", 64'(bus.cnt0), 64'(4));
        chk("rr_cnt1", 64'(bus.cnt1), 64'(4));
        chk("rr_ibf_done", 64'(bus.ibf_done), 64'(2'b11));
        chk("rr_sb_empty", 64'(exp_q.size()), 64'(0));
        chk("rr_accepts", 64'(acc_q.size()), 64'(8));
        for (int i = 1; i < acc_q.size(); i++) begin
            chk("rr_accept_gap", 64'(acc_q[i] - acc_q[i-1]), 64'(4));
        end

        // Timeout: datapath never answers
        reset_dut();
        resp_en = 1'b0;
        send(1'b0, 32'h1234, 1'b0, 1'b1);
        seen_start = 1'b0;
        for (int i = 0; i < 20 && !seen_start; i++) tick();
        n = 0;
        begin
            bit gone = 1'b0;
            while (n < 200 && !gone) begin
                tick();
                n++;
                if (!busy_s) gone = 1'b1;
            end
        end
        chk("tmo_cycles", 64'(n), 64'(TMO + 1));
        chk("tmo_err", 64'(bus.err), 64'(1));
        chk("tmo_cnt0", 64'(bus.cnt0), 64'(0));
        chk("tmo_ibf_done", 64'(bus.ibf_done), 64'(0));
        resp_en = 1'b1;
        send(1'b0, 32'h5678, 1'b1, 1'b1);
        wait_idle(100);
        chk("tmo_next_cnt0", 64'(bus.cnt0), 64'(1));
        chk("tmo_next_done", 64'(bus.ibf_done), 64'(2'b01));

        // dp_done coincident with dp_start is flagged and ignored
        reset_dut();
        resp_early = 1'b1;
        send(1'b1, 32'hBEEF, 1'b0, 1'b1);
        wait_idle(100);
        chk("early_err", 64'(bus.err), 64'(1));
        chk("early_cnt1", 64'(bus.cnt1), 64'(1));
        chk("early_ibf_done", 64'(bus.ibf_done), 64'(0));

        // Reset during WAIT, then a stale dp_done
        reset_dut();
        resp_en = 1'b0;
        send(1'b1, 32'hCAFE, 1'b1, 1'b1);
        seen_start = 1'b0;
        for (int i = 0; i < 20 && !seen_start; i++) tick();
        tick();
        chk("midwait_busy", 64'(bus.busy), 64'(1));
        reset_dut();
        done_pulse = 1'b1;
        tick();
        tick();
        check_quiet("stale_done", 1'b1);

        // Saturation with a 2-bit counter instance
        reset_dut();
        for (int i = 0; i < 5; i++) send(1'b1, 32'h100 + 32'(i), i == 4, 1'b1);
        n = 0;
        while (n < 300 && !(bus.ibf_done[1] && !bus.busy)) begin
            tick();
            n++;
        end
        chk("sat_main_cnt1", 64'(bus.cnt1), 64'(5));
        chk("sat_cnt1", 64'(sbus.cnt1), 64'(3));
        chk("sat_cnt0", 64'(sbus.cnt0), 64'(0));
        chk("sat_ibf_done", 64'(sbus.ibf_done), 64'(2'b10));
        chk("sat_sb_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
